// File: rtl/data_mem_resp_pkg.sv
// Shared constants and helpers for the data memory
// and its memory-mapped timer/GPIO block.
package data_mem_resp_pkg;

  localparam logic [3:0] MMIO_BASE   = 4'h1;

  localparam logic [2:0] OFF_COUNT   = 3'd0;
  localparam logic [2:0] OFF_COMPARE = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_GPIO    = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;

  localparam int CTRL_EN_BIT    = 0;
  localparam int STATUS_IRQ_BIT = 0;

  typedef struct packed {
    logic count;
    logic compare;
    logic status;
    logic gpio;
    logic ctrl;
  } mmio_wr_t;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old_v;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) r[8*n +: 8] = new_v[8*n +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_resp_timer.sv
// Free-running compare timer: COUNT, COMPARE,
// sticky STATUS flag and CTRL enable.
module data_mem_timer
  import data_mem_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic        wr_status_i,
  input  logic        wr_ctrl_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] ctrl_o,
  output logic        irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        irq_q, irq_d;
  logic        en_q, en_d;
  logic        match;
  logic        clr;

  assign match = en_q && (count_q == compare_q);
  assign clr   = wr_status_i
              && sel_i[STATUS_IRQ_BIT/8]
              && data_i[STATUS_IRQ_BIT];

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    irq_d     = irq_q;
    en_d      = en_q;
    if (en_q) count_d = count_q + 32'd1;
    // CPU write overrides the increment
    if (wr_count_i)
      count_d = lane_merge(count_q, data_i, sel_i);
    if (wr_compare_i)
      compare_d = lane_merge(compare_q, data_i, sel_i);
    if (match)    irq_d = 1'b1;
    else if (clr) irq_d = 1'b0;
    if (wr_ctrl_i && sel_i[CTRL_EN_BIT/8])
      en_d = data_i[CTRL_EN_BIT];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '0;
      irq_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
      en_q      <= en_d;
    end
  end

  always_comb begin
    status_o = '0;
    ctrl_o   = '0;
    status_o[STATUS_IRQ_BIT] = irq_q;
    ctrl_o[CTRL_EN_BIT]      = en_q;
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/data_mem_resp.sv
// CPU data port: word RAM with byte lanes plus an
// MMIO window holding the timer and a GPIO register.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o,
  output logic [31:0] gpio_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] gpio_q, gpio_d;

  logic                  is_mmio;
  logic [2:0]            off;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  wr;
  logic                  ram_we;
  mmio_wr_t              mw;

  logic [31:0] count, compare, status, ctrl;
  logic [31:0] mmio_rd;

  logic unused;
  assign unused = ^{addr_i[27:DEPTH_LOG2+2],
                    addr_i[1:0]};

  assign is_mmio = addr_i[31:28] == MMIO_BASE;
  assign off     = addr_i[4:2];
  assign widx    = addr_i[DEPTH_LOG2+1:2];
  assign wr      = ce_i && we_i;
  assign ram_we  = wr && !is_mmio;

  always_comb begin
    mw = '0;
    if (wr && is_mmio) begin
      unique case (1'b1)
        off == OFF_COUNT:   mw.count   = 1'b1;
        off == OFF_COMPARE: mw.compare = 1'b1;
        off == OFF_STATUS:  mw.status  = 1'b1;
        off == OFF_GPIO:    mw.gpio    = 1'b1;
        off == OFF_CTRL:    mw.ctrl    = 1'b1;
        default: ;
      endcase
    end
  end

  data_mem_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .wr_count_i   (mw.count),
    .wr_compare_i (mw.compare),
    .wr_status_i  (mw.status),
    .wr_ctrl_i    (mw.ctrl),
    .sel_i        (sel_i),
    .data_i       (data_i),
    .count_o      (count),
    .compare_o    (compare),
    .status_o     (status),
    .ctrl_o       (ctrl),
    .irq_o        (irq_o)
  );

  always_comb begin
    gpio_d = gpio_q;
    if (mw.gpio) gpio_d = lane_merge(gpio_q, data_i, sel_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gpio_q <= '0;
    else      gpio_q <= gpio_d;
  end

  // Contents survive reset; only the write is suppressed
  always_ff @(posedge clk or negedge rst) begin
    if (rst && ram_we) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_i[n])
          mem_q[widx][8*n +: 8] <= data_i[8*n +: 8];
      end
    end
  end

  always_comb begin
    mmio_rd = '0;
    unique case (1'b1)
      off == OFF_COUNT:   mmio_rd = count;
      off == OFF_COMPARE: mmio_rd = compare;
      off == OFF_STATUS:  mmio_rd = status;
      off == OFF_GPIO:    mmio_rd = gpio_q;
      off == OFF_CTRL:    mmio_rd = ctrl;
      default:            mmio_rd = '0;
    endcase
  end

  always_comb begin
    data_o = '0;
    if (ce_i && !we_i)
      data_o = is_mmio ? mmio_rd : mem_q[widx];
  end

  assign gpio_o = gpio_q;

endmodule
